// File: rtl/hi_pkg.sv
// Shared types and helpers for the host-interface register terminal.
package hi_pkg;

    typedef enum logic [1:0] {
        HI_IDLE = 2'd0,
        HI_RD   = 2'd1,
        HI_WR   = 2'd2
    } hi_state_e;

    localparam logic [15:0] HI_STATUS_OK    = 16'h0000;
    localparam logic [15:0] HI_STATUS_RANGE = 16'h0001;

    // Byte length rounded up to whole 32-bit words; the 33-bit sum keeps a near-max length from wrapping.
    function automatic logic [31:0] hi_len_to_words(input logic [31:0] len);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'd3;
        return {1'b0, sum[32:2]};
    endfunction

    function automatic logic hi_in_range(input logic [31:0] addr, input logic [31:0] num);
        return (addr < num);
    endfunction

endpackage

// File: rtl/hi_reg_term.sv
// Register terminal on the di_* bus: burst read/write access to NUM_REGS 32-bit registers
// with auto-incrementing word address and sticky out-of-range status.
module hi_reg_term
    import hi_pkg::*;
#(
    parameter logic [15:0] TERM_ADDR = 16'h0010,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    localparam int         AW        = $clog2(NUM_REGS)
) (
    input  logic                     ifclk,
    input  logic                     reset,
    input  logic [15:0]              di_term_addr,
    input  logic [31:0]              di_reg_addr,
    input  logic [31:0]              di_len,
    input  logic                     di_read_mode,
    input  logic                     di_read_req,
    input  logic                     di_read,
    output logic                     di_read_rdy,
    output logic [31:0]              di_reg_datao,
    input  logic                     di_write_mode,
    input  logic                     di_write,
    output logic                     di_write_rdy,
    input  logic [31:0]              di_reg_datai,
    output logic [15:0]              di_transfer_status,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic                     wr_strobe,
    output logic [AW-1:0]            wr_idx
);

    localparam logic [31:0] NUM_REGS_W = 32'(NUM_REGS);

    hi_state_e     state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   words_q, words_d;
    logic [15:0]   status_q, status_d;
    logic          rd_rdy_q, rd_rdy_d;
    logic          wr_rdy_q, wr_rdy_d;
    logic [31:0]   datao_q, datao_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [31:0]   regs_q [NUM_REGS];

    logic          sel_s;
    logic          start_rd_s;
    logic          fetch_en_s;
    logic [31:0]   fetch_addr_s;
    logic [31:0]   len_words_s;
    logic          we_s;
    logic [AW-1:0] we_idx_s;

    assign sel_s       = (di_term_addr == TERM_ADDR);
    assign len_words_s = hi_len_to_words(di_len);

    // Next-state, counter and read-fetch logic for the transfer FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_d      = words_q;
        status_d     = status_q;
        rd_rdy_d     = rd_rdy_q;
        wr_rdy_d     = wr_rdy_q;
        datao_d      = datao_q;
        wr_strobe_d  = 1'b0;
        wr_idx_d     = wr_idx_q;
        start_rd_s   = 1'b0;
        fetch_en_s   = 1'b0;
        fetch_addr_s = addr_q;
        we_s         = 1'b0;
        we_idx_s     = addr_q[AW-1:0];

        case (state_q)
            HI_IDLE: begin
                if (sel_s && di_read_mode && di_read_req) begin
                    start_rd_s = 1'b1;
                end else if (sel_s && di_write_mode) begin
                    state_d  = HI_WR;
                    addr_d   = di_reg_addr;
                    status_d = HI_STATUS_OK;
                    wr_rdy_d = 1'b1;
                end else begin
                    state_d = HI_IDLE;
                end
            end
            HI_RD: begin
                if (!sel_s || !di_read_mode) begin
                    state_d  = HI_IDLE;
                    rd_rdy_d = 1'b0;
                end else if (di_read_req) begin
                    start_rd_s = 1'b1;
                end else if (di_read && rd_rdy_q) begin
                    if (words_q == 32'd1) begin
                        state_d  = HI_IDLE;
                        rd_rdy_d = 1'b0;
                    end else begin
                        addr_d       = addr_q + 32'd1;
                        words_d      = words_q - 32'd1;
                        fetch_en_s   = 1'b1;
                        fetch_addr_s = addr_q + 32'd1;
                    end
                end else begin
                    state_d = HI_RD;
                end
            end
            HI_WR: begin
                if (!sel_s || !di_write_mode) begin
                    state_d  = HI_IDLE;
                    wr_rdy_d = 1'b0;
                end else if (di_write && wr_rdy_q) begin
                    addr_d = addr_q + 32'd1;
                    if (hi_in_range(addr_q, NUM_REGS_W)) begin
                        we_s        = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_idx_d    = addr_q[AW-1:0];
                    end else begin
                        status_d = HI_STATUS_RANGE;
                    end
                end else begin
                    state_d = HI_WR;
                end
            end
            default: begin
                state_d  = HI_IDLE;
                rd_rdy_d = 1'b0;
                wr_rdy_d = 1'b0;
            end
        endcase

        // A (re)start may come from IDLE or as a replayed request mid-read.
        if (start_rd_s) begin
            addr_d   = di_reg_addr;
            words_d  = len_words_s;
            status_d = HI_STATUS_OK;
            if (len_words_s == 32'd0) begin
                state_d  = HI_IDLE;
                rd_rdy_d = 1'b0;
            end else begin
                state_d      = HI_RD;
                rd_rdy_d     = 1'b1;
                fetch_en_s   = 1'b1;
                fetch_addr_s = di_reg_addr;
            end
        end else begin
            state_d = state_d;
        end

        if (fetch_en_s) begin
            if (hi_in_range(fetch_addr_s, NUM_REGS_W)) begin
                datao_d = regs_q[fetch_addr_s[AW-1:0]];
            end else begin
                datao_d  = 32'h0000_0000;
                status_d = HI_STATUS_RANGE;
            end
        end else begin
            datao_d = datao_d;
        end
    end

    // State, counters, registered outputs and the register file.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            state_q     <= HI_IDLE;
            addr_q      <= 32'h0000_0000;
            words_q     <= 32'h0000_0000;
            status_q    <= HI_STATUS_OK;
            rd_rdy_q    <= 1'b0;
            wr_rdy_q    <= 1'b0;
            datao_q     <= 32'h0000_0000;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            status_q    <= status_d;
            rd_rdy_q    <= rd_rdy_d;
            wr_rdy_q    <= wr_rdy_d;
            datao_q     <= datao_d;
            wr_strobe_q <= wr_strobe_d;
            wr_idx_q    <= wr_idx_d;
            if (we_s) begin
                regs_q[we_idx_s] <= di_reg_datai;
            end
        end
    end

    // Bus-facing outputs read as zero whenever another terminal is addressed.
    always_comb begin
        if (sel_s) begin
            di_read_rdy        = rd_rdy_q;
            di_write_rdy       = wr_rdy_q;
            di_reg_datao       = datao_q;
            di_transfer_status = status_q;
        end else begin
            di_read_rdy        = 1'b0;
            di_write_rdy       = 1'b0;
            di_reg_datao       = 32'h0000_0000;
            di_transfer_status = HI_STATUS_OK;
        end
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_idx    = wr_idx_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_hi_reg_term.sv
// Directed, table-driven bench for hi_reg_term with hand-written multi-cycle corner cases.
module tb_hi_reg_term;
    import hi_pkg::*;

    localparam int NR = 16;

    logic          ifclk = 1'b0;
    logic          reset;
    logic [15:0]   di_term_addr;
    logic [31:0]   di_reg_addr, di_len, di_reg_datai;
    logic          di_read_mode, di_read_req, di_read, di_write_mode, di_write;
    logic          di_read_rdy, di_write_rdy, wr_strobe;
    logic [31:0]   di_reg_datao;
    logic [15:0]   di_transfer_status;
    logic [32*NR-1:0] regs_o;
    logic [3:0]    wr_idx;

    int checks = 0;
    int errors = 0;

    hi_reg_term #(.TERM_ADDR(16'h0010), .NUM_REGS(NR), .RESET_VAL(32'h0000_0000)) dut (
        .ifclk(ifclk), .reset(reset),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
        .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
        .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
        .di_write_mode(di_write_mode), .di_write(di_write), .di_write_rdy(di_write_rdy),
        .di_reg_datai(di_reg_datai), .di_transfer_status(di_transfer_status),
        .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_idx(wr_idx)
    );

    always #5 ifclk = ~ifclk;

    typedef struct {
        logic [15:0] term;
        logic [31:0] raddr;
        logic [31:0] len;
        logic        rm, rq, rd, wm, wr;
        logic [31:0] wdat;
        logic        e_rrdy;
        logic        e_dchk;
        logic [31:0] e_dato;
        logic        e_wrdy;
        logic [15:0] e_stat;
        logic        e_stb;
        logic [3:0]  e_idx;
    } vec_t;

    localparam logic [31:0] DA = 32'hA0A0_0001;
    localparam logic [31:0] DB = 32'hB0B0_0002;
    localparam logic [31:0] DC = 32'hC0C0_0003;
    localparam logic [31:0] DD = 32'hD0D0_0004;
    localparam logic [31:0] DE = 32'hE0E0_0005;
    localparam logic [31:0] DF = 32'hF0F0_0006;
    localparam logic [31:0] DX = 32'h1234_5678;
    localparam logic [31:0] DY = 32'h9ABC_DEF0;
    localparam logic [31:0] DZ = 32'h5A5A_A5A5;
    localparam logic [31:0] DW = 32'h0BAD_F00D;

    vec_t vecs [19];
    logic [32*NR-1:0] exp_regs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm, input logic [32*NR-1:0] exp);
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (regs_o[32*k +: 32] !== exp[32*k +: 32]) begin
                errors++;
                $display("FAIL %s reg%0d: got %h expected %h", nm, k, regs_o[32*k +: 32], exp[32*k +: 32]);
            end
        end
    endtask

    task automatic drive(input logic [15:0] term, input logic [31:0] raddr, input logic [31:0] len,
                         input logic rm, input logic rq, input logic rd,
                         input logic wm, input logic wr, input logic [31:0] wdat);
        di_term_addr  = term;
        di_reg_addr   = raddr;
        di_len        = len;
        di_read_mode  = rm;
        di_read_req   = rq;
        di_read       = rd;
        di_write_mode = wm;
        di_write      = wr;
        di_reg_datai  = wdat;
    endtask

    task automatic tick();
        @(posedge ifclk);
        #1;
    endtask

    initial begin
        //             term    raddr   len     rm    rq    rd    wm    wr    wdat  rrdy  dchk  dato  wrdy  stat   stb   idx
        vecs[0]  = '{16'h10, 32'd2,  32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 16'h0, 1'b0, 4'd0};
        vecs[1]  = '{16'h10, 32'd2,  32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DA,    1'b0, 1'b1, 32'h0, 1'b1, 16'h0, 1'b1, 4'd2};
        vecs[2]  = '{16'h10, 32'd2,  32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DB,    1'b0, 1'b1, 32'h0, 1'b1, 16'h0, 1'b1, 4'd3};
        vecs[3]  = '{16'h10, 32'd2,  32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DC,    1'b0, 1'b1, 32'h0, 1'b1, 16'h0, 1'b1, 4'd4};
        vecs[4]  = '{16'h10, 32'd2,  32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 1'b0, 4'd4};
        vecs[5]  = '{16'h10, 32'd2,  32'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, DA,    1'b0, 16'h0, 1'b0, 4'd4};
        vecs[6]  = '{16'h10, 32'd2,  32'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, DB,    1'b0, 16'h0, 1'b0, 4'd4};
        vecs[7]  = '{16'h10, 32'd2,  32'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, DC,    1'b0, 16'h0, 1'b0, 4'd4};
        vecs[8]  = '{16'h10, 32'd2,  32'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 4'd4};
        vecs[9]  = '{16'h10, 32'd0,  32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 4'd4};
        vecs[10] = '{16'h10, 32'd15, 32'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 16'h0, 1'b0, 4'd4};
        vecs[11] = '{16'h10, 32'd15, 32'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DD,    1'b0, 1'b0, 32'h0, 1'b1, 16'h0, 1'b1, 4'd15};
        vecs[12] = '{16'h10, 32'd15, 32'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DE,    1'b0, 1'b0, 32'h0, 1'b1, 16'h1, 1'b0, 4'd15};
        vecs[13] = '{16'h10, 32'd15, 32'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h1, 1'b0, 4'd15};
        vecs[14] = '{16'h10, 32'd0,  32'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 16'h0, 1'b0, 4'd15};
        vecs[15] = '{16'h10, 32'd0,  32'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 4'd15};
        vecs[16] = '{16'h10, 32'd0,  32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 4'd15};
        vecs[17] = '{16'h11, 32'd0,  32'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DF,    1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 1'b0, 4'd15};
        vecs[18] = '{16'h11, 32'd0,  32'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DF,    1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 1'b0, 4'd15};

        // Reset state, observed with this terminal selected so gating cannot hide it.
        reset = 1'b1;
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_read_rdy", 32'(di_read_rdy), 32'd0);
        chk("rst_write_rdy", 32'(di_write_rdy), 32'd0);
        chk("rst_datao", di_reg_datao, 32'h0);
        chk("rst_status", 32'(di_transfer_status), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_idx", 32'(wr_idx), 32'd0);
        exp_regs = '0;
        chk_regs("rst_regs", exp_regs);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].term, vecs[i].raddr, vecs[i].len, vecs[i].rm, vecs[i].rq, vecs[i].rd,
                  vecs[i].wm, vecs[i].wr, vecs[i].wdat);
            tick();
            chk($sformatf("v%0d_read_rdy", i), 32'(di_read_rdy), 32'(vecs[i].e_rrdy));
            if (vecs[i].e_dchk) chk($sformatf("v%0d_datao", i), di_reg_datao, vecs[i].e_dato);
            chk($sformatf("v%0d_write_rdy", i), 32'(di_write_rdy), 32'(vecs[i].e_wrdy));
            chk($sformatf("v%0d_status", i), 32'(di_transfer_status), 32'(vecs[i].e_stat));
            chk($sformatf("v%0d_wr_strobe", i), 32'(wr_strobe), 32'(vecs[i].e_stb));
            chk($sformatf("v%0d_wr_idx", i), 32'(wr_idx), 32'(vecs[i].e_idx));
        end
        exp_regs[32*2 +: 32]  = DA;
        exp_regs[32*3 +: 32]  = DB;
        exp_regs[32*4 +: 32]  = DC;
        exp_regs[32*15 +: 32] = DD;
        chk_regs("table_regs", exp_regs);

        // Seed reg0/reg1 with distinct values for the abort/replay sequence.
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DX);    tick();
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DY);    tick();
        chk("seed_idx", 32'(wr_idx), 32'd1);
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();

        // Abort after one word, then a late request, then a replayed request inside RD.
        drive(16'h10, 32'd0, 32'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("ab_first_rdy", 32'(di_read_rdy), 32'd1);
        chk("ab_first_data", di_reg_datao, DX);
        drive(16'h10, 32'd0, 32'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        chk("ab_second_data", di_reg_datao, DY);
        drive(16'h10, 32'd0, 32'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("ab_drop_rdy", 32'(di_read_rdy), 32'd0);
        drive(16'h10, 32'd0, 32'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("ab_noreq_rdy0", 32'(di_read_rdy), 32'd0);
        tick();
        chk("ab_noreq_rdy1", 32'(di_read_rdy), 32'd0);
        drive(16'h10, 32'd0, 32'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("ab_late_rdy", 32'(di_read_rdy), 32'd1);
        chk("ab_late_data", di_reg_datao, DX);
        drive(16'h10, 32'd0, 32'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        chk("ab_adv_data", di_reg_datao, DY);
        drive(16'h10, 32'd2, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("replay_rdy", 32'(di_read_rdy), 32'd1);
        chk("replay_data", di_reg_datao, DA);
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();

        // Zero-length read never raises ready.
        drive(16'h10, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("zero_len_rdy", 32'(di_read_rdy), 32'd0);
        drive(16'h10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("zero_len_rdy2", 32'(di_read_rdy), 32'd0);
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();

        // Address counter wraps from all-ones to 0; status stays set while reg0 is still written.
        drive(16'h10, 32'hFFFF_FFFF, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        drive(16'h10, 32'hFFFF_FFFF, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DZ);    tick();
        chk("wrap_drop_stb", 32'(wr_strobe), 32'd0);
        chk("wrap_drop_status", 32'(di_transfer_status), 32'd1);
        tick();
        chk("wrap_stb", 32'(wr_strobe), 32'd1);
        chk("wrap_idx", 32'(wr_idx), 32'd0);
        chk("wrap_status", 32'(di_transfer_status), 32'd1);
        chk("wrap_reg0", regs_o[31:0], DZ);
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();

        // Reset in the middle of a write burst.
        drive(16'h10, 32'd5, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        drive(16'h10, 32'd5, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DW);    tick();
        chk("mid_stb", 32'(wr_strobe), 32'd1);
        chk("mid_idx", 32'(wr_idx), 32'd5);
        chk("mid_reg5", regs_o[32*5 +: 32], DW);
        reset = 1'b1;
        tick();
        chk("mid_rst_wrdy", 32'(di_write_rdy), 32'd0);
        chk("mid_rst_stb", 32'(wr_strobe), 32'd0);
        chk("mid_rst_idx", 32'(wr_idx), 32'd0);
        exp_regs = '0;
        chk_regs("mid_rst_regs", exp_regs);
        reset = 1'b0;
        drive(16'h10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        chk("post_rst_wrdy", 32'(di_write_rdy), 32'd0);
        chk("post_rst_rrdy", 32'(di_read_rdy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
